rsc_encoder: RTL
================

RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 40: number of information bits per frame, range 4..6144.
REQ-002 SHALL have parameter AMP, default 1024: BPSK symbol magnitude, signed 16-bit, range 1..32767.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_bit is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_bit this cycle.
REQ-007 SHALL have port in_bit  input  1  information bit.
REQ-008 SHALL have port out_valid  output  1  the output symbol pair is valid.
REQ-009 SHALL have port out_ready  input  1  the downstream decoder accepts the symbol pair.
REQ-010 SHALL have port out_sys  output  16 signed  systematic symbol.
REQ-011 SHALL have port out_par  output  16 signed  parity symbol.
REQ-012 SHALL have port out_first  output  1  first symbol pair of the frame.
REQ-013 SHALL have port out_last  output  1  final symbol pair of the frame.
REQ-014 SHALL have port out_tail  output  1  symbol pair is a termination (tail) pair.

Function
REQ-015 SHALL implement the 8-state RSC code with feedback 1+D^2+D^3 and feedforward 1+D+D^3; register s1 (newest), s2, s3.
REQ-016 Per data step: a = u^s2^s3; p = a^s1^s3; then s1<=a, s2<=s1, s3<=s2.
REQ-017 SHALL map bit 0 to +AMP and bit 1 to -AMP, for both out_sys and out_par.
REQ-018 A transfer occurs on in_valid&&in_ready; out_valid SHALL rise on the next cycle (latency 1).
REQ-019 in_ready SHALL equal (state is IDLE or DATA) && (!out_valid || out_ready).
REQ-020 While out_valid&&!out_ready, all out_* SHALL hold stable; no symbol is dropped or duplicated.
REQ-021 The FSM SHALL have states IDLE, DATA and TAIL, with these transitions:
  - IDLE->DATA on the first accepted bit; out_first is set on that pair.
  - DATA->TAIL after the FRAME_LEN-th accepted bit.
  - TAIL->IDLE after the third tail pair is loaded into the output register.
REQ-022 In TAIL, in_ready SHALL be 0 and u SHALL be s2^s3, so that a=0.
REQ-023 In TAIL, out_sys SHALL map u, out_par SHALL map s1^s3, and out_tail SHALL be 1.
REQ-024 A tail pair SHALL be loaded only when !out_valid || out_ready.
REQ-025 After the three tail steps, the state s1..s3 SHALL be 000.
REQ-026 The bit counter SHALL count 0..FRAME_LEN-1, wrap to 0 at the frame end, and never exceed FRAME_LEN-1.
REQ-027 out_last SHALL mark the third tail pair.
REQ-028 Back-to-back frames SHALL be supported: the next frame's first bit is accepted in the cycle the last tail pair is consumed.

Reset
REQ-029 On rst=1 at a clock edge, the following SHALL apply:
  - state=IDLE, s1..s3=0, counter=0.
  - out_valid=0, out_sys=0, out_par=0, out_first=0, out_last=0, out_tail=0, in_ready=0.
REQ-030 rst SHALL take priority over every transfer, including a mid-frame or mid-tail reset; pending output is discarded.
REQ-031 in_ready SHALL be 1 from the first cycle after rst deasserts.

Configuration
REQ-032 Macro RSC_TERM_EN, when defined, SHALL enable trellis termination: TAIL state, out_tail and the 3 tail pairs, as in REQ-021..REQ-025.
REQ-033 Without RSC_TERM_EN:
  - DATA->IDLE directly after bit FRAME_LEN.
  - out_last marks the last data pair.
  - s1..s3 are cleared to 0 on that transition.
  - out_tail is tied 0.

Verification
REQ-034 Reset, then one frame of 40 zeros -> 43 pairs (sys,par)=(+1024,+1024); out_first on pair 1, out_tail on pairs 41..43, out_last on pair 43.
REQ-035 Inputs 1,0,0 from reset -> pairs (-1024,-1024), (+1024,-1024), (+1024,-1024).
REQ-036 out_ready held 0 for 5 cycles mid-frame -> outputs frozen and in_ready=0; the stream resumes with no gap or loss, checked against a reference model.
REQ-037 Random 40-bit frame, random valid/ready -> after the tail, state=000; sequence matches the model.
REQ-038 rst asserted during TAIL pair 2 -> next cycle out_valid=0, state IDLE; the next frame encodes from the zero state.
REQ-039 Build without RSC_TERM_EN, 40-bit frame -> exactly 40 pairs, out_last on pair 40, out_tail never 1.

Source files
------------

// File: rtl/rsc_encoder.sv
// 8-state recursive systematic convolutional encoder (fb 1+D^2+D^3, ff 1+D+D^3) with BPSK mapping.
// Define RSC_TERM_EN to append three trellis-termination (tail) pairs after each frame.
module rsc_encoder #(
  parameter int unsigned        FRAME_LEN = 40,
  parameter logic signed [15:0] AMP       = 16'sd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_sys,
  output logic signed [15:0] out_par,
  output logic               out_first,
  output logic               out_last,
  output logic               out_tail
);

  localparam int unsigned      CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
`ifdef RSC_TERM_EN
  logic [1:0]       tail_cnt;
`endif

  logic slot_free;
  logic accept;
  logic frame_end;
  logic a_bit;
  logic p_bit;

  // The output register can take a new pair when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && (state == IDLE || state == DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign frame_end = (cnt == LAST_IDX);
  assign a_bit     = in_bit ^ s2 ^ s3;
  assign p_bit     = a_bit ^ s1 ^ s3;

  function automatic logic signed [15:0] bpsk(input logic b);
    return b ? -AMP : AMP;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
`ifdef RSC_TERM_EN
      tail_cnt  <= 2'd0;
`endif
      out_valid <= 1'b0;
      out_sys   <= 16'sd0;
      out_par   <= 16'sd0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_tail  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_sys   <= bpsk(in_bit);
        out_par   <= bpsk(p_bit);
        out_first <= (cnt == '0);
        out_tail  <= 1'b0;
        s1        <= a_bit;
        s2        <= s1;
        s3        <= s2;
        if (frame_end) begin
          cnt <= '0;
`ifdef RSC_TERM_EN
          out_last <= 1'b0;
          state    <= TAIL;
`else
          // Unterminated frame: restart the next frame from the zero state.
          out_last <= 1'b1;
          state    <= IDLE;
          s1       <= 1'b0;
          s2       <= 1'b0;
          s3       <= 1'b0;
`endif
        end else begin
          cnt      <= cnt + CNT_W'(1);
          out_last <= 1'b0;
          state    <= DATA;
        end
      end
`ifdef RSC_TERM_EN
      // Tail input u = s2^s3 forces the feedback bit to zero, flushing the register.
      else if (state == TAIL && slot_free) begin
        out_valid <= 1'b1;
        out_sys   <= bpsk(s2 ^ s3);
        out_par   <= bpsk(s1 ^ s3);
        out_first <= 1'b0;
        out_last  <= (tail_cnt == 2'd2);
        out_tail  <= 1'b1;
        s1        <= 1'b0;
        s2        <= s1;
        s3        <= s2;
        if (tail_cnt == 2'd2) begin
          tail_cnt <= 2'd0;
          state    <= IDLE;
        end else begin
          tail_cnt <= tail_cnt + 2'd1;
        end
      end
`endif
    end
  end

endmodule
